// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-1 control sequencer: opcodes, state
// encodings and the control-word bit order (pc_out is the MSB).
package sap_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned TS_W = 3;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_LDA = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB = 4'h3;
  localparam logic [OP_W-1:0] OP_STA = 4'h4;
  localparam logic [OP_W-1:0] OP_LDI = 4'h5;
  localparam logic [OP_W-1:0] OP_JMP = 4'h6;
  localparam logic [OP_W-1:0] OP_JC  = 4'h7;
  localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [TS_W-1:0] {
    ST_T0   = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  typedef struct packed {
    logic pc_out;
    logic pc_inc;
    logic pc_load;
    logic mar_load;
    logic ram_out;
    logic ram_in;
    logic ir_load;
    logic ir_out;
    logic a_load;
    logic a_out;
    logic b_load;
    logic alu_out;
    logic alu_sub;
    logic flags_load;
    logic out_load;
  } ctrl_word_t;

  localparam int unsigned CW_W = $bits(ctrl_word_t);

endpackage

// File: rtl/sap_ucode_rom.sv
// Microcode decode: opcode x T-state -> control word, plus sequencing hints.
// Ports:
//   state          current sequencer state
//   opcode         instruction register upper nibble
//   flag_c, flag_z registered ALU flags (conditional jumps)
//   cw_c           ungated control word for this state
//   last_c         this state is the final one of the instruction
//   halt_c         this state moves the sequencer to HALT
module sap_ucode_rom
  import sap_pkg::*;
(
  input  state_e          state,
  input  logic [OP_W-1:0] opcode,
  input  logic            flag_c,
  input  logic            flag_z,
  output ctrl_word_t      cw_c,
  output logic            last_c,
  output logic            halt_c
);

  // Decode table; HALT and unused codes emit nothing.
  always_comb begin
    cw_c   = '0;
    last_c = 1'b0;
    halt_c = 1'b0;
    case (state)
      ST_T0: begin
        cw_c.pc_out   = 1'b1;
        cw_c.mar_load = 1'b1;
      end
      ST_T1: begin
        cw_c.ram_out = 1'b1;
        cw_c.ir_load = 1'b1;
        cw_c.pc_inc  = 1'b1;
      end
      ST_T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw_c.ir_out   = 1'b1;
            cw_c.mar_load = 1'b1;
          end
          OP_LDI: begin
            cw_c.ir_out = 1'b1;
            cw_c.a_load = 1'b1;
            last_c      = 1'b1;
          end
          OP_JMP: begin
            cw_c.ir_out  = 1'b1;
            cw_c.pc_load = 1'b1;
            last_c       = 1'b1;
          end
          OP_JC: begin
            cw_c.ir_out  = flag_c;
            cw_c.pc_load = flag_c;
            last_c       = 1'b1;
          end
          OP_JZ: begin
            cw_c.ir_out  = flag_z;
            cw_c.pc_load = flag_z;
            last_c       = 1'b1;
          end
          OP_OUT: begin
            cw_c.a_out    = 1'b1;
            cw_c.out_load = 1'b1;
            last_c        = 1'b1;
          end
          OP_HLT:  halt_c = 1'b1;
          default: last_c = 1'b1;  // NOP and undefined opcodes
        endcase
      end
      ST_T3: begin
        case (opcode)
          OP_LDA: begin
            cw_c.ram_out = 1'b1;
            cw_c.a_load  = 1'b1;
            last_c       = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw_c.ram_out = 1'b1;
            cw_c.b_load  = 1'b1;
          end
          OP_STA: begin
            cw_c.a_out  = 1'b1;
            cw_c.ram_in = 1'b1;
            last_c      = 1'b1;
          end
          default: last_c = 1'b1;
        endcase
      end
      ST_T4: begin
        cw_c.alu_out    = 1'b1;
        cw_c.a_load     = 1'b1;
        cw_c.flags_load = 1'b1;
        cw_c.alu_sub    = (opcode == OP_SUB);
        last_c          = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP-1 control sequencer: T-state machine with free-run / single-step
// stepping, clock enable and HALT; strobes come from sap_ucode_rom.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   ena                   clock enable (low freezes and silences strobes)
//   opcode, flag_c/z      instruction nibble and ALU flags
//   step_mode, step       single-step select and step request
//   pc_out..out_load      datapath control strobes (combinational)
//   tstate, halted        current T-state (0 while halted) and HALT flag
module sap_control_sequencer
  import sap_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [OP_W-1:0] opcode,
  input  logic            flag_c,
  input  logic            flag_z,
  input  logic            step_mode,
  input  logic            step,
  output logic            pc_out,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            mar_load,
  output logic            ram_out,
  output logic            ram_in,
  output logic            ir_load,
  output logic            ir_out,
  output logic            a_load,
  output logic            a_out,
  output logic            b_load,
  output logic            alu_out,
  output logic            alu_sub,
  output logic            flags_load,
  output logic            out_load,
  output logic [TS_W-1:0] tstate,
  output logic            halted
);

  state_e     state_q, state_d;
  logic       step_q;
  logic       step_rise_c;
  logic       advance_c;
  logic       rom_last_c;
  logic       rom_halt_c;
  ctrl_word_t rom_cw_c;
  ctrl_word_t cw_c;

  // A state advances every enabled cycle, or only on a step rising edge.
  assign step_rise_c = step & ~step_q;
  assign advance_c   = ena & (~step_mode | step_rise_c);

  sap_ucode_rom u_rom (
    .state  (state_q),
    .opcode (opcode),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .cw_c   (rom_cw_c),
    .last_c (rom_last_c),
    .halt_c (rom_halt_c)
  );

  // State register and step edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_T0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step;
    end
  end

  // Next-state: HALT is sticky; otherwise return to T0 or step forward.
  always_comb begin
    state_d = state_q;
    if (advance_c) begin
      if (rom_halt_c) begin
        state_d = ST_HALT;
      end else if (rom_last_c) begin
        state_d = ST_T0;
      end else begin
        case (state_q)
          ST_T0:   state_d = ST_T1;
          ST_T1:   state_d = ST_T2;
          ST_T2:   state_d = ST_T3;
          ST_T3:   state_d = ST_T4;
          default: state_d = state_q;
        endcase
      end
    end
  end

  // Strobes only fire on an advance cycle and never while reset is held.
  always_comb begin
    cw_c = '0;
    if (rst_n && advance_c) begin
      cw_c = rom_cw_c;
    end
  end

  assign pc_out     = cw_c.pc_out;
  assign pc_inc     = cw_c.pc_inc;
  assign pc_load    = cw_c.pc_load;
  assign mar_load   = cw_c.mar_load;
  assign ram_out    = cw_c.ram_out;
  assign ram_in     = cw_c.ram_in;
  assign ir_load    = cw_c.ir_load;
  assign ir_out     = cw_c.ir_out;
  assign a_load     = cw_c.a_load;
  assign a_out      = cw_c.a_out;
  assign b_load     = cw_c.b_load;
  assign alu_out    = cw_c.alu_out;
  assign alu_sub    = cw_c.alu_sub;
  assign flags_load = cw_c.flags_load;
  assign out_load   = cw_c.out_load;

  assign halted = (state_q == ST_HALT);
  assign tstate = halted ? TS_W'(0) : TS_W'(state_q);

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed bench for sap_control_sequencer.
module tb_sap_control_sequencer;

  // Strobe masks, bit order pc_out (14) down to out_load (0).
  localparam logic [14:0] S_PC_OUT  = 15'h4000;
  localparam logic [14:0] S_PC_INC  = 15'h2000;
  localparam logic [14:0] S_PC_LOAD = 15'h1000;
  localparam logic [14:0] S_MAR     = 15'h0800;
  localparam logic [14:0] S_RAM_OUT = 15'h0400;
  localparam logic [14:0] S_RAM_IN  = 15'h0200;
  localparam logic [14:0] S_IR_LOAD = 15'h0100;
  localparam logic [14:0] S_IR_OUT  = 15'h0080;
  localparam logic [14:0] S_A_LOAD  = 15'h0040;
  localparam logic [14:0] S_A_OUT   = 15'h0020;
  localparam logic [14:0] S_B_LOAD  = 15'h0010;
  localparam logic [14:0] S_ALU_OUT = 15'h0008;
  localparam logic [14:0] S_ALU_SUB = 15'h0004;
  localparam logic [14:0] S_FLAGS   = 15'h0002;
  localparam logic [14:0] S_OUT     = 15'h0001;
  localparam logic [14:0] S_NONE    = 15'h0000;

  localparam logic [14:0] S_T0 = S_PC_OUT | S_MAR;
  localparam logic [14:0] S_T1 = S_RAM_OUT | S_IR_LOAD | S_PC_INC;
  localparam logic [14:0] S_ADDR = S_IR_OUT | S_MAR;
  localparam logic [14:0] S_JUMP = S_IR_OUT | S_PC_LOAD;
  localparam logic [14:0] S_ADD4 = S_ALU_OUT | S_A_LOAD | S_FLAGS;

  logic       clk = 1'b0;
  logic       rst_n, ena, flag_c, flag_z, step_mode, step;
  logic [3:0] opcode;
  logic       pc_out, pc_inc, pc_load, mar_load, ram_out, ram_in, ir_load, ir_out;
  logic       a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load;
  logic [2:0] tstate;
  logic       halted;
  logic [14:0] strobes;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sap_control_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .opcode     (opcode),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .step_mode  (step_mode),
    .step       (step),
    .pc_out     (pc_out),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .mar_load   (mar_load),
    .ram_out    (ram_out),
    .ram_in     (ram_in),
    .ir_load    (ir_load),
    .ir_out     (ir_out),
    .a_load     (a_load),
    .a_out      (a_out),
    .b_load     (b_load),
    .alu_out    (alu_out),
    .alu_sub    (alu_sub),
    .flags_load (flags_load),
    .out_load   (out_load),
    .tstate     (tstate),
    .halted     (halted)
  );

  assign strobes = {pc_out, pc_inc, pc_load, mar_load, ram_out, ram_in, ir_load,
                    ir_out, a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: checks this cycle's state/strobes, moves to next cycle.
  task automatic cyc(input string tag, input logic [2:0] ts, input logic [14:0] s);
    #1;
    check({tag, "/tstate"}, 32'(tstate), 32'(ts));
    check({tag, "/strobes"}, 32'(strobes), 32'(s));
    @(posedge clk);
    #1;
  endtask

  // One step pulse (advance cycle) followed by one idle cycle with step low.
  task automatic pulse(input string tag, input logic [2:0] ts, input logic [14:0] s,
                       input logic [2:0] ts_after);
    step = 1'b1;
    cyc({tag, "_p"}, ts, s);
    step = 1'b0;
    cyc({tag, "_g"}, ts_after, S_NONE);
  endtask

  // Bus drivers must be one-hot-or-zero every cycle.
  always @(negedge clk) begin
    checks++;
    assert ($onehot0({pc_out, ram_out, ir_out, a_out, alu_out})) else begin
      errors++;
      $error("FAIL bus_onehot observed=0x%0h expected=onehot0",
             {pc_out, ram_out, ir_out, a_out, alu_out});
    end
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
    step_mode = 1'b0; step = 1'b0;

    // Reset state, with ena high
    #3;
    check("rst/tstate", 32'(tstate), 32'd0);
    check("rst/halted", 32'(halted), 32'd0);
    check("rst/strobes", 32'(strobes), 32'(S_NONE));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Program: LDI 5, ADD, OUT, HLT
    opcode = 4'h5;
    cyc("ldi_t0", 3'd0, S_T0);
    cyc("ldi_t1", 3'd1, S_T1);
    cyc("ldi_t2", 3'd2, S_IR_OUT | S_A_LOAD);
    opcode = 4'h2;
    cyc("add_t0", 3'd0, S_T0);
    cyc("add_t1", 3'd1, S_T1);
    cyc("add_t2", 3'd2, S_ADDR);
    cyc("add_t3", 3'd3, S_RAM_OUT | S_B_LOAD);
    cyc("add_t4", 3'd4, S_ADD4);
    opcode = 4'hE;
    cyc("out_t0", 3'd0, S_T0);
    cyc("out_t1", 3'd1, S_T1);
    cyc("out_t2", 3'd2, S_A_OUT | S_OUT);
    opcode = 4'hF;
    cyc("hlt_t0", 3'd0, S_T0);
    cyc("hlt_t1", 3'd1, S_T1);
    #1;
    check("hlt_t2/halted", 32'(halted), 32'd0);
    #1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      check("halt/halted", 32'(halted), 32'd1);
      cyc("halt", 3'd0, S_NONE);
    end

    // Reset out of HALT
    rst_n = 1'b0;
    #1;
    check("rst_halt/halted", 32'(halted), 32'd0);
    check("rst_halt/strobes", 32'(strobes), 32'(S_NONE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset mid-T3 of ADD aborts immediately
    opcode = 4'h2;
    cyc("radd_t0", 3'd0, S_T0);
    cyc("radd_t1", 3'd1, S_T1);
    cyc("radd_t2", 3'd2, S_ADDR);
    #1;
    check("radd_t3/strobes", 32'(strobes), 32'(S_RAM_OUT | S_B_LOAD));
    rst_n = 1'b0;
    #1;
    check("radd_rst/tstate", 32'(tstate), 32'd0);
    check("radd_rst/strobes", 32'(strobes), 32'(S_NONE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("post_rst_t0", 3'd0, S_T0);
    cyc("post_rst_t1", 3'd1, S_T1);
    cyc("post_rst_t2", 3'd2, S_ADDR);
    cyc("post_rst_t3", 3'd3, S_RAM_OUT | S_B_LOAD);
    cyc("post_rst_t4", 3'd4, S_ADD4);

    // SUB adds alu_sub in T4
    opcode = 4'h3;
    cyc("sub_t0", 3'd0, S_T0);
    cyc("sub_t1", 3'd1, S_T1);
    cyc("sub_t2", 3'd2, S_ADDR);
    cyc("sub_t3", 3'd3, S_RAM_OUT | S_B_LOAD);
    cyc("sub_t4", 3'd4, S_ADD4 | S_ALU_SUB);

    // Conditional jumps
    opcode = 4'h7; flag_c = 1'b0; flag_z = 1'b1;
    cyc("jc0_t0", 3'd0, S_T0);
    cyc("jc0_t1", 3'd1, S_T1);
    cyc("jc0_t2", 3'd2, S_NONE);
    flag_c = 1'b1; flag_z = 1'b0;
    cyc("jc1_t0", 3'd0, S_T0);
    cyc("jc1_t1", 3'd1, S_T1);
    cyc("jc1_t2", 3'd2, S_JUMP);
    opcode = 4'h8;
    cyc("jz0_t0", 3'd0, S_T0);
    cyc("jz0_t1", 3'd1, S_T1);
    cyc("jz0_t2", 3'd2, S_NONE);
    flag_c = 1'b0; flag_z = 1'b1;
    cyc("jz1_t0", 3'd0, S_T0);
    cyc("jz1_t1", 3'd1, S_T1);
    cyc("jz1_t2", 3'd2, S_JUMP);
    flag_z = 1'b0;

    // Single-step: step held high gives exactly one advance
    step_mode = 1'b1; opcode = 4'h0;
    cyc("stp_idle", 3'd0, S_NONE);
    cyc("stp_idle", 3'd0, S_NONE);
    step = 1'b1;
    cyc("stp_hold0", 3'd0, S_T0);
    for (int i = 0; i < 9; i++) cyc("stp_hold", 3'd1, S_NONE);
    step = 1'b0;
    cyc("stp_rel", 3'd1, S_NONE);
    pulse("nop1", 3'd1, S_T1, 3'd2);
    pulse("nop2", 3'd2, S_NONE, 3'd0);

    // Four pulses walk an ADD from T0 to T4, a fifth completes it
    opcode = 4'h2;
    pulse("sadd0", 3'd0, S_T0, 3'd1);
    pulse("sadd1", 3'd1, S_T1, 3'd2);
    pulse("sadd2", 3'd2, S_ADDR, 3'd3);
    pulse("sadd3", 3'd3, S_RAM_OUT | S_B_LOAD, 3'd4);
    pulse("sadd4", 3'd4, S_ADD4, 3'd0);

    // Leaving step mode mid-instruction keeps the current T-state
    opcode = 4'h0;
    pulse("mode0", 3'd0, S_T0, 3'd1);
    step_mode = 1'b0;
    cyc("mode_t1", 3'd1, S_T1);
    cyc("mode_t2", 3'd2, S_NONE);

    // Clock enable low during STA T3
    opcode = 4'h4;
    cyc("sta_t0", 3'd0, S_T0);
    cyc("sta_t1", 3'd1, S_T1);
    cyc("sta_t2", 3'd2, S_ADDR);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) cyc("ena_off", 3'd3, S_NONE);
    ena = 1'b1;
    cyc("sta_t3", 3'd3, S_A_OUT | S_RAM_IN);
    cyc("sta_done", 3'd0, S_T0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
